// File: rtl/nco_pkg.sv
// Shared constants and FSM state encoding for the multichannel NCO sequencer.
package nco_pkg;
  localparam int ROM_ADDR_W  = 8;
  localparam int ROM_DATA_W  = 8;
  localparam int NUM_CH_DEF  = 4;
  localparam int PHASE_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/nco_scheduler_if.sv
// Configuration, sweep strobe and tagged sample stream of the NCO sequencer.
interface nco_scheduler_if #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 16,
  parameter int CH_W    = $clog2(NUM_CH)
);
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [PHASE_W-1:0] cfg_ftw;
  logic               cfg_en;
  logic               cfg_clr;
  logic               tick;
  logic               busy;
  logic               sample_valid;
  logic [CH_W-1:0]    sample_ch;
  logic [7:0]         sample_data;
  logic               overrun;

  modport master (
    output cfg_we, cfg_ch, cfg_ftw, cfg_en, cfg_clr, tick,
    input  busy, sample_valid, sample_ch, sample_data, overrun
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_ftw, cfg_en, cfg_clr, tick,
    output busy, sample_valid, sample_ch, sample_data, overrun
  );
endinterface

// File: rtl/sin_generator.sv
// 256-entry sine ROM, amplitude +/-42, built from a quarter-wave table.
// One registered read stage; output is two's complement.
module sin_generator
  import nco_pkg::*;
(
  input  logic [ROM_ADDR_W-1:0] address,
  input  logic                  clock,
  output logic [ROM_DATA_W-1:0] q
);
  localparam logic [6:0] QTAB [0:64] = '{
    7'd0,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  7'd7,
    7'd8,  7'd9,  7'd10, 7'd11, 7'd12, 7'd13, 7'd14, 7'd15,
    7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd22, 7'd22,
    7'd23, 7'd24, 7'd25, 7'd26, 7'd27, 7'd27, 7'd28, 7'd29,
    7'd30, 7'd30, 7'd31, 7'd32, 7'd32, 7'd33, 7'd34, 7'd34,
    7'd35, 7'd35, 7'd36, 7'd37, 7'd37, 7'd38, 7'd38, 7'd38,
    7'd39, 7'd39, 7'd40, 7'd40, 7'd40, 7'd40, 7'd41, 7'd41,
    7'd41, 7'd41, 7'd42, 7'd42, 7'd42, 7'd42, 7'd42, 7'd42,
    7'd42
  };

  logic [6:0]            w_idx;
  logic [6:0]            w_mag;
  logic [ROM_DATA_W-1:0] w_val;

  // Bit 6 mirrors the quarter, bit 7 selects the negative half.
  always_comb begin
    w_idx = address[6] ? (7'd64 - {1'b0, address[5:0]}) : {1'b0, address[5:0]};
    w_mag = QTAB[w_idx];
    w_val = address[7] ? (8'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
  end

  always_ff @(posedge clock) begin
    q <= w_val;
  end
endmodule

// File: rtl/nco_scheduler.sv
// Time-shares one sine ROM across NUM_CH phase accumulators; each tick sweeps
// all channels in order and emits one tagged sample per enabled channel.
module nco_scheduler
  import nco_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic clock,
  input  logic reset,
  nco_scheduler_if.slave bus
);
  logic [PHASE_W-1:0]    r_phase [NUM_CH];
  logic [PHASE_W-1:0]    r_ftw   [NUM_CH];
  logic [NUM_CH-1:0]     r_en;
  logic [NUM_CH-1:0]     r_en_snap;
  state_t                r_state;
  logic [CH_W-1:0]       r_idx;
  logic                  r_iss_vld;
  logic [CH_W-1:0]       r_iss_tag;
  logic                  r_overrun;

  logic                  w_issue;
  logic [ROM_ADDR_W-1:0] w_rom_addr;
  logic [ROM_DATA_W-1:0] w_rom_q;

  assign w_issue    = (r_state == ISSUE) && r_en_snap[r_idx];
  assign w_rom_addr = r_phase[r_idx][PHASE_W-1 -: ROM_ADDR_W];

  sin_generator u_rom (
    .address (w_rom_addr),
    .clock   (clock),
    .q       (w_rom_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_phase[i] <= '0;
        r_ftw[i]   <= '0;
      end
      r_en      <= '0;
      r_en_snap <= '0;
      r_state   <= IDLE;
      r_idx     <= '0;
      r_iss_vld <= 1'b0;
      r_iss_tag <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.tick) begin
            r_en_snap <= r_en;
            r_idx     <= '0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_idx == CH_W'(NUM_CH - 1)) r_state <= DRAIN;
          else                            r_idx   <= r_idx + CH_W'(1);
        end
        DRAIN:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (bus.tick && (r_state != IDLE)) r_overrun <= 1'b1;

      r_iss_vld <= w_issue;
      r_iss_tag <= w_issue ? r_idx : '0;

      if (w_issue) r_phase[r_idx] <= r_phase[r_idx] + r_ftw[r_idx];

      // Placed after the accumulate so a clear on the issue cycle wins.
      if (bus.cfg_we) begin
        r_ftw[bus.cfg_ch] <= bus.cfg_ftw;
        r_en[bus.cfg_ch]  <= bus.cfg_en;
        if (bus.cfg_clr) r_phase[bus.cfg_ch] <= '0;
      end
    end
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.sample_valid = r_iss_vld;
  assign bus.sample_ch    = r_iss_tag;
  assign bus.sample_data  = r_iss_vld ? w_rom_q : '0;
  assign bus.overrun      = r_overrun;
endmodule
